// File: rtl/conv2d_frame_ctrl_if.sv
// Stream bundle around the conv2d frame sequencer: upstream beat in, tagged beat out.
// Signal directions are named from the sequencer's point of view.
interface conv2d_frame_ctrl_if #(
  parameter int unsigned width_p = 16
);
  logic               valid_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               valid_o;
  logic               ready_i;
  logic [width_p-1:0] data_o;
  logic               sof_o;
  logic               eol_o;
  logic               eof_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, sof_o, eol_o, eof_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, sof_o, eol_o, eof_o
  );
endinterface

// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer for the 3x3 conv2d output stream: drops warm-up/line-wrap beats, tags SOF/EOL/EOF.
// Optional CONV2D_FRAME_CTRL_STATS_EN adds saturating frame and drop counters.
module conv2d_frame_ctrl #(
  parameter int unsigned linewidth_px_p = 16,
  parameter int unsigned lines_p        = 16,
  parameter int unsigned width_p        = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  conv2d_frame_ctrl_if.slave   stream,
  output logic                 frame_done_o
`ifdef CONV2D_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]          frame_count_o,
  output logic [15:0]          drop_count_o
`endif
);

  localparam int unsigned COL_W = $clog2(linewidth_px_p);
  localparam int unsigned ROW_W = $clog2(lines_p);

  typedef enum logic {FILL, ACTIVE} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic               accept_c, col_last_c, row_last_c, keep_c, done_c;
  logic               valid_q, sof_q, eol_q, eof_q;
  logic [width_p-1:0] data_q;

  assign stream.ready_o = ~valid_q | stream.ready_i;
  assign accept_c       = stream.valid_i & stream.ready_o;
  assign col_last_c     = (col_q == COL_W'(linewidth_px_p - 1));
  assign row_last_c     = (row_q == ROW_W'(lines_p - 1));

  assign stream.valid_o = valid_q;
  assign stream.data_o  = data_q;
  assign stream.sof_o   = sof_q;
  assign stream.eol_o   = eol_q;
  assign stream.eof_o   = eof_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= FILL;
    else         state_q <= state_d;
  end

  // Row phase: FILL covers the two warm-up rows, ACTIVE the rows holding full windows.
  always_comb begin
    state_d = state_q;
    keep_c  = 1'b0;
    done_c  = 1'b0;
    if (clear_i) begin
      state_d = FILL;
    end else if (accept_c) begin
      case (state_q)
        FILL: begin
          if (row_q == ROW_W'(1) && col_last_c) state_d = ACTIVE;
        end
        ACTIVE: begin
          keep_c = (col_q >= COL_W'(2));
          if (row_last_c && col_last_c) begin
            state_d = FILL;
            done_c  = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept_c) begin
      if (col_last_c) begin
        col_q <= '0;
        row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Single output register; a held beat only leaves when downstream takes it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      data_q       <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= done_c;
      if (keep_c) begin
        valid_q <= 1'b1;
        data_q  <= stream.data_i;
        sof_q   <= (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
        eol_q   <= col_last_c;
        eof_q   <= row_last_c && col_last_c;
      end else if (accept_c || stream.ready_i) begin
        valid_q <= 1'b0;
        sof_q   <= 1'b0;
        eol_q   <= 1'b0;
        eof_q   <= 1'b0;
      end
    end
  end

`ifdef CONV2D_FRAME_CTRL_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_count_o <= '0;
      drop_count_o  <= '0;
    end else begin
      if (done_c && frame_count_o != 16'hFFFF) frame_count_o <= frame_count_o + 16'd1;
      if (accept_c && !keep_c && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Directed bench for conv2d_frame_ctrl at W=4, H=4, width 16.
module tb_conv2d_frame_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          fd;
  } beat_t;

  logic clk = 1'b0;
  logic reset_i;
  logic clear_i;
  logic frame_done_o;
`ifdef CONV2D_FRAME_CTRL_STATS_EN
  logic [15:0] frame_count_o;
  logic [15:0] drop_count_o;
`endif

  int    cmp_cnt = 0;
  int    err_cnt = 0;
  int    done_cnt = 0;
  beat_t out_q[$];

  always #5 clk = ~clk;

  conv2d_frame_ctrl_if #(.width_p(DW)) bus ();

  conv2d_frame_ctrl #(
    .linewidth_px_p(W),
    .lines_p(H),
    .width_p(DW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .clear_i(clear_i),
    .stream(bus.slave),
    .frame_done_o(frame_done_o)
`ifdef CONV2D_FRAME_CTRL_STATS_EN
    ,
    .frame_count_o(frame_count_o),
    .drop_count_o(drop_count_o)
`endif
  );

  // Records every beat taken downstream, plus frame_done pulses.
  always @(negedge clk) begin
    beat_t b;
    if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      b.d   = bus.data_o;
      b.sof = bus.sof_o;
      b.eol = bus.eol_o;
      b.eof = bus.eof_o;
      b.fd  = frame_done_o;
      out_q.push_back(b);
    end
    if (frame_done_o === 1'b1) done_cnt++;
  end

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    bus.data_i  = 16'hDEAD;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic clr);
    int n = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    clear_i     = clr;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", d, n);
    end
    @(posedge clk);
    #1;
    clear_i = 1'b0;
  endtask

  task automatic start_test();
    idle(4);
    out_q.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    clear_i     = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++;
    if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
    cmp_cnt++;
    if ({bus.sof_o, bus.eol_o, bus.eof_o, frame_done_o} !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_tags: got %b expected 0000", {bus.sof_o, bus.eol_o, bus.eof_o, frame_done_o});
    end
    cmp_cnt++;
    if (bus.ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
`ifdef CONV2D_FRAME_CTRL_STATS_EN
    cmp_cnt++;
    if (frame_count_o !== 16'd0 || drop_count_o !== 16'd0) begin
      err_cnt++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", frame_count_o, drop_count_o);
    end
`endif
    reset_i = 1'b0;
  endtask

  task automatic test_frame_ramp();
    logic [DW-1:0] exp_d [4] = '{16'd10, 16'd11, 16'd14, 16'd15};
    logic [3:0]    exp_t [4] = '{4'b1000, 4'b0100, 4'b0000, 4'b0111};
    start_test();
    for (int i = 0; i < 16; i++) send_beat(DW'(i), 1'b0);
    idle(3);
    cmp_cnt++;
    if (out_q.size() !== 4) begin err_cnt++; $display("FAIL ramp_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      cmp_cnt++;
      if (out_q[i].d !== exp_d[i]) begin err_cnt++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_d[i]); end
      cmp_cnt++;
      if ({out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd} !== exp_t[i]) begin
        err_cnt++; $display("FAIL ramp_tags[%0d]: got %b expected %b", i, {out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd}, exp_t[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL ramp_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] exp_d [4] = '{16'd10, 16'd11, 16'd14, 16'd15};
    start_test();
    for (int i = 0; i <= 10; i++) send_beat(DW'(i), 1'b0);
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 16'd11;
    repeat (4) begin
      @(negedge clk);
      cmp_cnt++;
      if (bus.ready_o !== 1'b0) begin err_cnt++; $display("FAIL stall_ready: got %b expected 0", bus.ready_o); end
      cmp_cnt++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== 16'd10) begin
        err_cnt++; $display("FAIL stall_hold: got valid %b data %0d expected 1/10", bus.valid_o, bus.data_o);
      end
      cmp_cnt++;
      if (bus.sof_o !== 1'b1) begin err_cnt++; $display("FAIL stall_sof: got %b expected 1", bus.sof_o); end
    end
    @(posedge clk);
    #1;
    bus.ready_i = 1'b1;
    for (int i = 11; i < 16; i++) send_beat(DW'(i), 1'b0);
    idle(3);
    cmp_cnt++;
    if (out_q.size() !== 4) begin err_cnt++; $display("FAIL bp_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      cmp_cnt++;
      if (out_q[i].d !== exp_d[i]) begin err_cnt++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [8] = '{16'd10, 16'd11, 16'd14, 16'd15, 16'd26, 16'd27, 16'd30, 16'd31};
    logic [3:0]    exp_t [8] = '{4'b1000, 4'b0100, 4'b0000, 4'b0111, 4'b1000, 4'b0100, 4'b0000, 4'b0111};
    start_test();
    for (int i = 0; i < 32; i++) send_beat(DW'(i), 1'b0);
    idle(3);
    cmp_cnt++;
    if (out_q.size() !== 8) begin err_cnt++; $display("FAIL b2b_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      cmp_cnt++;
      if (out_q[i].d !== exp_d[i]) begin err_cnt++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_d[i]); end
      cmp_cnt++;
      if ({out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd} !== exp_t[i]) begin
        err_cnt++; $display("FAIL b2b_tags[%0d]: got %b expected %b", i, {out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd}, exp_t[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 2) begin err_cnt++; $display("FAIL b2b_done: got %0d expected 2", done_cnt); end
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] exp_d [4] = '{16'd10, 16'd11, 16'd14, 16'd15};
    logic [3:0]    exp_t [4] = '{4'b1000, 4'b0100, 4'b0000, 4'b0111};
    start_test();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      send_beat(DW'(i), 1'b0);
    end
    idle(3);
    cmp_cnt++;
    if (out_q.size() !== 4) begin err_cnt++; $display("FAIL bub_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      cmp_cnt++;
      if (out_q[i].d !== exp_d[i]) begin err_cnt++; $display("FAIL bub_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_d[i]); end
      cmp_cnt++;
      if ({out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd} !== exp_t[i]) begin
        err_cnt++; $display("FAIL bub_tags[%0d]: got %b expected %b", i, {out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd}, exp_t[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL bub_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_clear();
    logic [DW-1:0] exp_d [4] = '{16'd110, 16'd111, 16'd114, 16'd115};
    logic [3:0]    exp_t [4] = '{4'b1000, 4'b0100, 4'b0000, 4'b0111};
    start_test();
    for (int i = 0; i < 7; i++) send_beat(DW'(i), 1'b0);
    send_beat(16'd7, 1'b1);
    for (int i = 0; i < 16; i++) send_beat(DW'(100 + i), 1'b0);
    idle(3);
    cmp_cnt++;
    if (out_q.size() !== 4) begin err_cnt++; $display("FAIL clr_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      cmp_cnt++;
      if (out_q[i].d !== exp_d[i]) begin err_cnt++; $display("FAIL clr_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_d[i]); end
      cmp_cnt++;
      if ({out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd} !== exp_t[i]) begin
        err_cnt++; $display("FAIL clr_tags[%0d]: got %b expected %b", i, {out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd}, exp_t[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL clr_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] exp_d [4] = '{16'd10, 16'd11, 16'd14, 16'd15};
    logic [3:0]    exp_t [4] = '{4'b1000, 4'b0100, 4'b0000, 4'b0111};
    start_test();
    for (int i = 0; i < 12; i++) send_beat(DW'(i), 1'b0);
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 16'd12;
    @(negedge clk);
    cmp_cnt++;
    if (bus.valid_o !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_valid: got %b expected 1", bus.valid_o); end
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i     = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    cmp_cnt++;
    if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b expected 0", bus.valid_o); end
    cmp_cnt++;
    if ({bus.sof_o, bus.eol_o, bus.eof_o, frame_done_o} !== 4'b0000) begin
      err_cnt++; $display("FAIL rst_tags: got %b expected 0000", {bus.sof_o, bus.eol_o, bus.eof_o, frame_done_o});
    end
    out_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 16; i++) send_beat(DW'(i), 1'b0);
    idle(3);
    cmp_cnt++;
    if (out_q.size() !== 4) begin err_cnt++; $display("FAIL rst_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      cmp_cnt++;
      if (out_q[i].d !== exp_d[i]) begin err_cnt++; $display("FAIL rst_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_d[i]); end
      cmp_cnt++;
      if ({out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd} !== exp_t[i]) begin
        err_cnt++; $display("FAIL rst_tags[%0d]: got %b expected %b", i, {out_q[i].sof, out_q[i].eol, out_q[i].eof, out_q[i].fd}, exp_t[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL rst_done: got %0d expected 1", done_cnt); end
`ifdef CONV2D_FRAME_CTRL_STATS_EN
    cmp_cnt++;
    if (frame_count_o !== 16'd1) begin err_cnt++; $display("FAIL stats_frames: got %0d expected 1", frame_count_o); end
    cmp_cnt++;
    if (drop_count_o !== 16'd12) begin err_cnt++; $display("FAIL stats_drops: got %0d expected 12", drop_count_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_frame_ramp();
    test_back_pressure();
    test_back_to_back();
    test_bubbles();
    test_clear();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
